// File: rtl/grade_scroller_pkg.sv
// Shared types and seven-segment constants for the grade scroller.
// Segment order is {g,f,e,d,c,b,a}; the dash carries dp in bit 7.
package grade_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHOW_GRADE, SHOW_STATUS} state_t;

  typedef enum logic [1:0] {
    MODE_GRADE  = 2'b00,
    MODE_STATUS = 2'b01,
    MODE_ALT    = 2'b10
  } mode_t;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_P = 7'b1110011;
  localparam logic [6:0] SEG_F = 7'b1110001;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_I = 7'b0000110;
  localparam logic [7:0] SEG_DASH = 8'b0100_0000;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_I;
    endcase
  endfunction

  // Encoding 2'b11 is not a mode of its own; it behaves as grade-only.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_STATUS;
      2'b10:   return MODE_ALT;
      default: return MODE_GRADE;
    endcase
  endfunction

endpackage

// File: rtl/grade_scroller_if.sv
// Write/control and display bus of the grade scroller.
// master: switch/strobe logic; slave: grade_scroller.
interface grade_scroller_if #(
  parameter int NGRADES     = 4,
  parameter int NBITS_GRADE = 4
);
  logic                         wr_en;
  logic [NBITS_GRADE-1:0]       wr_data;
  logic                         clear;
  logic [1:0]                   mode;
  logic [7:0]                   seg;
  logic [$clog2(NGRADES)-1:0]   idx;
  logic [$clog2(NGRADES):0]     count;
  logic                         full;
  logic                         empty;
  logic                         ovf;

  modport master (
    output wr_en, wr_data, clear, mode,
    input  seg, idx, count, full, empty, ovf
  );

  modport slave (
    input  wr_en, wr_data, clear, mode,
    output seg, idx, count, full, empty, ovf
  );
endinterface

// File: rtl/grade_scroller_seg_enc.sv
// Combinational grade -> seven-segment encoder (digit or status letter).
// Grades above MAX_GRADE show "I" in either view.
module grade_seg_enc
  import grade_disp_pkg::*;
#(
  parameter int NBITS_GRADE = 4,
  parameter int MAX_GRADE   = 10
) (
  input  logic [NBITS_GRADE-1:0] grade,
  input  logic                   show_status,
  output logic [6:0]             seg7
);

  logic [7:0] g;
  assign g = 8'(grade);

  // Select digit/letter pattern for the current grade
  always_comb begin
    seg7 = SEG_I;
    if (g > 8'(MAX_GRADE)) begin
      seg7 = SEG_I;
    end else if (show_status) begin
      if (g < 8'd4)      seg7 = SEG_P;
      else if (g < 8'd7) seg7 = SEG_F;
      else               seg7 = SEG_A;
    end else if (g <= 8'd9) begin
      seg7 = digit_seg(g[3:0]);
    end else if (g == 8'd10) begin
      seg7 = SEG_D;
    end
  end

endmodule

// File: rtl/grade_scroller.sv
// Grade buffer plus scanning display FSM driving one seven-segment digit.
// Optional macro GRADE_SCROLLER_DP_MARK_EN: lights dp while entry 0 is shown.
module grade_scroller
  import grade_disp_pkg::*;
#(
  parameter int NGRADES     = 4,
  parameter int NBITS_GRADE = 4,
  parameter int DWELL       = 5,
  parameter int MAX_GRADE   = 10
) (
  input logic             clk_2,
  input logic             reset,
  grade_scroller_if.slave bus
);

  localparam int IW = $clog2(NGRADES);
  localparam int CW = IW + 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [NBITS_GRADE-1:0] grade_buf [NGRADES];
  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DW-1:0]          dwell_q, dwell_d;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          idx_inc;
  logic                   ovf_q;
  logic                   full;
  logic                   dp;
  logic [6:0]             seg7;
  logic [7:0]             seg_q, seg_d;
  mode_t                  md;

  assign full    = (count_q == CW'(NGRADES));
  assign md      = decode_mode(bus.mode);
  assign idx_inc = CW'(idx_q) + CW'(1);

  // Buffer storage; contents after reset/clear are don't-care
  always_ff @(posedge clk_2) begin
    if (bus.wr_en && !bus.clear && !full)
      grade_buf[count_q[IW-1:0]] <= bus.wr_data;
  end

  // Fill level and sticky overflow; clear takes priority over a write
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.wr_en) begin
      if (full) ovf_q   <= 1'b1;
      else      count_q <= count_q + CW'(1);
    end
  end

  // FSM state, scan index and dwell counter registers
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
    end
  end

  // Next state: mode is only consulted when a dwell completes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = (md == MODE_STATUS) ? SHOW_STATUS : SHOW_GRADE;
          idx_d   = '0;
          dwell_d = '0;
        end
      end
      SHOW_GRADE, SHOW_STATUS: begin
        if (dwell_q == DW'(DWELL - 1)) begin
          dwell_d = '0;
          if (md == MODE_ALT && state_q == SHOW_GRADE) begin
            state_d = SHOW_STATUS;
          end else begin
            idx_d   = (idx_inc == count_q) ? '0 : idx_inc[IW-1:0];
            state_d = (md == MODE_STATUS) ? SHOW_STATUS : SHOW_GRADE;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        dwell_d = '0;
      end
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      idx_d   = '0;
      dwell_d = '0;
    end
  end

  grade_seg_enc #(
    .NBITS_GRADE (NBITS_GRADE),
    .MAX_GRADE   (MAX_GRADE)
  ) u_enc (
    .grade       (grade_buf[idx_q]),
    .show_status (state_q == SHOW_STATUS),
    .seg7        (seg7)
  );

`ifdef GRADE_SCROLLER_DP_MARK_EN
  assign dp = (idx_q == '0);
`else
  assign dp = 1'b0;
`endif

  assign seg_d = (state_q == IDLE) ? SEG_DASH : {dp, seg7};

  // Output register: seg reflects the (state, idx) of the previous cycle
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset)          seg_q <= SEG_DASH;
    else if (bus.clear) seg_q <= SEG_DASH;
    else                seg_q <= seg_d;
  end

  assign bus.seg   = seg_q;
  assign bus.idx   = idx_q;
  assign bus.count = count_q;
  assign bus.full  = full;
  assign bus.empty = (count_q == '0);
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_grade_scroller.sv
// Directed scoreboard bench for grade_scroller (NGRADES=4, DWELL=2).
module tb_grade_scroller;

  typedef struct {
    int unsigned idx;
    logic [7:0]  seg;
  } exp_t;

  logic clk_2;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];
  int unsigned prev_idx;
  logic [3:0] wdata [8];

  grade_scroller_if #(.NGRADES(4), .NBITS_GRADE(4)) bus ();

  grade_scroller #(
    .NGRADES     (4),
    .NBITS_GRADE (4),
    .DWELL       (2),
    .MAX_GRADE   (10)
  ) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned i, input logic [7:0] s);
    exp_t e;
    e.idx = i;
    e.seg = s;
    sb.push_back(e);
  endtask

  // Pops one expected (idx, seg) pair; dp tracks the entry shown, i.e. the previous idx
  task automatic sb_pop();
    exp_t e;
    logic [7:0] s;
    e = sb.pop_front();
    s = e.seg;
`ifdef GRADE_SCROLLER_DP_MARK_EN
    if (e.seg != 8'h40 && prev_idx == 0) s[7] = 1'b1;
`endif
    chk("scan_seg", 32'(bus.seg), 32'(s));
    chk("scan_idx", 32'(bus.idx), e.idx);
    prev_idx = e.idx;
  endtask

  // From an empty buffer: write wdata[0..nw-1] one per cycle, then drain the scoreboard
  task automatic scan_test(input int nw);
    prev_idx = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > nw && sb.size() == 0) break;
      bus.wr_en = (k <= nw);
      if (k <= nw) bus.wr_data = wdata[k-1];
      tick();
      if (k <= nw) begin
        chk("wr_count", 32'(bus.count), (k < 4) ? k : 4);
        chk("wr_full", 32'(bus.full), (k >= 4) ? 1 : 0);
        chk("wr_ovf", 32'(bus.ovf), (k > 4) ? 1 : 0);
      end
      if (k >= 2 && sb.size() > 0) sb_pop();
    end
    bus.wr_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_seg", 32'(bus.seg), 32'h40);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    prev_idx = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clear   = 1'b0;
    bus.mode    = 2'b00;

    // Reset state, then idle with no writes
    tick();
    chk("rst_seg", 32'(bus.seg), 32'h40);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_seg", 32'(bus.seg), 32'h40);
      chk("idle_empty", 32'(bus.empty), 1);
      chk("idle_idx", 32'(bus.idx), 0);
    end

    // Mode 00: grades 3, 7, 11 (11 shows "I")
    bus.mode = 2'b00;
    wdata[0] = 4'd3; wdata[1] = 4'd7; wdata[2] = 4'd11;
    push(0, 8'h40); push(0, 8'h4F); push(1, 8'h4F); push(1, 8'h07); push(2, 8'h07);
    push(2, 8'h06); push(0, 8'h06); push(0, 8'h4F); push(1, 8'h4F);
    scan_test(3);
    do_clear();

    // Mode 10: single grade 5 alternates digit and F
    bus.mode = 2'b10;
    wdata[0] = 4'd5;
    push(0, 8'h40); push(0, 8'h6D); push(0, 8'h6D); push(0, 8'h71); push(0, 8'h71);
    push(0, 8'h6D); push(0, 8'h6D); push(0, 8'h71); push(0, 8'h71);
    scan_test(1);
    do_clear();

    // Mode 11 (as 00): five writes into four slots, fifth never shown
    bus.mode = 2'b11;
    wdata[0] = 4'd1; wdata[1] = 4'd2; wdata[2] = 4'd4; wdata[3] = 4'd8; wdata[4] = 4'd9;
    push(0, 8'h40); push(0, 8'h06); push(1, 8'h06); push(1, 8'h5B); push(2, 8'h5B);
    push(2, 8'h66); push(3, 8'h66); push(3, 8'h7F); push(0, 8'h7F); push(0, 8'h06);
    push(1, 8'h06);
    scan_test(5);

    // clear and wr_en together while scanning: clear wins
    bus.clear   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 4'd3;
    tick();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    chk("cw_count", 32'(bus.count), 0);
    chk("cw_empty", 32'(bus.empty), 1);
    chk("cw_seg", 32'(bus.seg), 32'h40);
    chk("cw_ovf", 32'(bus.ovf), 0);
    chk("cw_idx", 32'(bus.idx), 0);
    chk("cw_full", 32'(bus.full), 0);
    tick();
    chk("cw_drop_count", 32'(bus.count), 0);
    chk("cw_drop_seg", 32'(bus.seg), 32'h40);

    // Mode 01: status letters P, I, A, F
    bus.mode = 2'b01;
    wdata[0] = 4'd2; wdata[1] = 4'd12; wdata[2] = 4'd9; wdata[3] = 4'd6;
    push(0, 8'h40); push(0, 8'h73); push(1, 8'h73); push(1, 8'h06); push(2, 8'h06);
    push(2, 8'h77); push(3, 8'h77); push(3, 8'h71); push(0, 8'h71); push(0, 8'h73);
    push(1, 8'h73);
    scan_test(4);

    // Asynchronous reset mid-cycle while in SHOW_STATUS
    #2;
    reset = 1'b1;
    #1;
    chk("arst_seg", 32'(bus.seg), 32'h40);
    chk("arst_idx", 32'(bus.idx), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_full", 32'(bus.full), 0);
    chk("arst_ovf", 32'(bus.ovf), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_seg", 32'(bus.seg), 32'h40);
    chk("post_rst_count", 32'(bus.count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
